// File: rtl/adc_clk_div_gen.sv
// adc_clk_div_gen: NUM_CH programmable divided clocks and strobes from refclk.
// Define ADC_CLK_DIV_GEN_PHASE_EN to build per-channel phase offsets.
module adc_clk_div_gen #(
    parameter int NUM_CH      = 5,
    parameter int CNT_W       = 16,
    parameter int LOCK_CYCLES = 16,
    localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int LK_W       = $clog2(LOCK_CYCLES + 2)
) (
    input  logic              refclk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_div,
    input  logic [CNT_W-1:0]  cfg_phase,
    output logic [NUM_CH-1:0] outclk,
    output logic [NUM_CH-1:0] stb,
    output logic              locked,
    output logic              busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ALIGN,
        S_RUN
    } state_e;

    localparam logic [CH_W:0]    NCH    = (CH_W + 1)'(NUM_CH);
    localparam logic [LK_W-1:0]  LK_MAX = LK_W'(LOCK_CYCLES);
    localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(2);

    state_e state_q, state_d;

    logic [CNT_W-1:0] div_q [NUM_CH];
    logic [CNT_W-1:0] div_d [NUM_CH];
    logic [CNT_W-1:0] sh_q  [NUM_CH];
    logic [CNT_W-1:0] sh_d  [NUM_CH];
    logic [CNT_W-1:0] cnt_q [NUM_CH];
    logic [CNT_W-1:0] cnt_d [NUM_CH];

    logic [NUM_CH-1:0] pend_q, pend_d;
    logic [NUM_CH-1:0] oclk_q, oclk_d;
    logic [NUM_CH-1:0] stb_q, stb_d;
    logic [NUM_CH-1:0] hit;
    logic [LK_W-1:0]   lk_q, lk_d;
    logic              locked_q, locked_d;
    logic              busy_q, busy_d;

    logic              wr_ok;
    logic              in_run;
    logic              run_nx;
    logic              run_wr;
    logic [CNT_W-1:0]  div_n;

    // Ratios below 2 cannot produce both a high and a low phase.
    assign div_n  = (cfg_div < DIV_RST) ? DIV_RST : cfg_div;
    assign wr_ok  = cfg_we && ({1'b0, cfg_ch} < NCH);
    assign in_run = en && (state_q == S_RUN);
    assign run_nx = en && (state_q != S_IDLE);
    assign run_wr = in_run && (|hit);
    assign busy_d = |pend_d;

    always_comb begin
        hit = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            hit[i] = wr_ok && (cfg_ch == CH_W'(i));
        end
    end

`ifdef ADC_CLK_DIV_GEN_PHASE_EN
    logic [CNT_W-1:0] phase_q [NUM_CH];
    logic [CNT_W-1:0] phase_d [NUM_CH];
    logic             align;

    assign align = en && (state_q == S_ALIGN);

    function automatic logic [CNT_W-1:0] preload(
        input logic [CNT_W-1:0] d,
        input logic [CNT_W-1:0] p
    );
        logic [CNT_W-1:0] pc;
        pc = (p >= d) ? d - CNT_W'(1) : p;
        return (pc == '0) ? '0 : d - pc;
    endfunction

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                phase_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                phase_q[i] <= phase_d[i];
            end
        end
    end
`else
    logic unused_phase;
    assign unused_phase = ^cfg_phase;
`endif

    always_comb begin
        state_d  = state_q;
        lk_d     = lk_q;
        locked_d = 1'b0;

        unique case (state_q)
            S_IDLE:  if (en) state_d = S_ALIGN;
            S_ALIGN: state_d = S_RUN;
            S_RUN:   state_d = S_RUN;
            default: state_d = S_IDLE;
        endcase
        if (!en) state_d = S_IDLE;

        for (int i = 0; i < NUM_CH; i++) begin
            div_d[i]  = div_q[i];
            sh_d[i]   = sh_q[i];
            pend_d[i] = pend_q[i];
            cnt_d[i]  = '0;

            if (in_run) begin
                if (cnt_q[i] >= div_q[i] - CNT_W'(1)) begin
                    if (pend_q[i]) begin
                        div_d[i]  = sh_q[i];
                        pend_d[i] = 1'b0;
                    end
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end else if (pend_q[i]) begin
                // Leaving RUN commits any shadowed ratio.
                div_d[i]  = sh_q[i];
                pend_d[i] = 1'b0;
            end

            if (hit[i]) begin
                if (in_run) begin
                    sh_d[i]   = div_n;
                    pend_d[i] = 1'b1;
                end else begin
                    div_d[i] = div_n;
                end
            end

`ifdef ADC_CLK_DIV_GEN_PHASE_EN
            phase_d[i] = hit[i] ? cfg_phase : phase_q[i];
            if (align) cnt_d[i] = preload(div_d[i], phase_d[i]);
`endif

            oclk_d[i] = run_nx && (cnt_d[i] < (div_d[i] >> 1));
            stb_d[i]  = run_nx && (cnt_d[i] == '0);
        end

        if (in_run) begin
            if (run_wr || busy_q) begin
                lk_d = '0;
            end else if (lk_q != LK_MAX) begin
                lk_d = lk_q + LK_W'(1);
            end
            locked_d = !run_wr && !busy_q && (lk_d == LK_MAX);
        end else begin
            lk_d = '0;
        end
    end

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            pend_q   <= '0;
            oclk_q   <= '0;
            stb_q    <= '0;
            lk_q     <= '0;
            locked_q <= 1'b0;
            busy_q   <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                div_q[i] <= DIV_RST;
                sh_q[i]  <= DIV_RST;
                cnt_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            pend_q   <= pend_d;
            oclk_q   <= oclk_d;
            stb_q    <= stb_d;
            lk_q     <= lk_d;
            locked_q <= locked_d;
            busy_q   <= busy_d;
            for (int i = 0; i < NUM_CH; i++) begin
                div_q[i] <= div_d[i];
                sh_q[i]  <= sh_d[i];
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign outclk = oclk_q;
    assign stb    = stb_q;
    assign locked = locked_q;
    assign busy   = busy_q;

endmodule

// File: tb/tb_adc_clk_div_gen.sv
// tb_adc_clk_div_gen: directed bring-up then random traffic vs. a
// time-based reference model of the divided clocks.
module tb_adc_clk_div_gen;

    localparam int NCH = 5;
    localparam int CW  = 16;
    localparam int LC  = 16;

    logic           refclk = 1'b0;
    logic           rst_n = 1'b0;
    logic           en = 1'b0;
    logic           cfg_we = 1'b0;
    logic [2:0]     cfg_ch = '0;
    logic [CW-1:0]  cfg_div = '0;
    logic [CW-1:0]  cfg_phase = '0;
    logic [NCH-1:0] outclk;
    logic [NCH-1:0] stb;
    logic           locked;
    logic           busy;

    int total = 0;
    int bad = 0;

    adc_clk_div_gen #(
        .NUM_CH(NCH),
        .CNT_W(CW),
        .LOCK_CYCLES(LC)
    ) dut (
        .refclk(refclk),
        .rst_n(rst_n),
        .en(en),
        .cfg_we(cfg_we),
        .cfg_ch(cfg_ch),
        .cfg_div(cfg_div),
        .cfg_phase(cfg_phase),
        .outclk(outclk),
        .stb(stb),
        .locked(locked),
        .busy(busy)
    );

    always #5 refclk = ~refclk;

    // Model: each channel's period started at edge m_t0; its state after
    // edge t is simply t - m_t0 within a period of m_div cycles.
    int m_div [NCH];
    int m_q   [NCH];
    int m_ph  [NCH];
    int m_t0  [NCH];
    int ms;
    int lk;
    int t;
    logic [NCH-1:0] e_oclk;
    logic [NCH-1:0] e_stb;
    logic           e_lock;
    logic           e_busy;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    task automatic mreset();
        for (int i = 0; i < NCH; i++) begin
            m_div[i] = 2;
            m_q[i]   = 0;
            m_ph[i]  = 0;
            m_t0[i]  = 0;
        end
        ms = 0;
        lk = 0;
        e_oclk = '0;
        e_stb  = '0;
        e_lock = 1'b0;
        e_busy = 1'b0;
    endtask

    task automatic model_edge();
        bit ok;
        bit runwr;
        bit bprev;
        bit hit;
        int dv;
        int ph;
        t++;
        ok = cfg_we && (int'(cfg_ch) < NCH);
        dv = (int'(cfg_div) < 2) ? 2 : int'(cfg_div);
        runwr = ok && (ms == 2) && en;
        bprev = e_busy;
        e_oclk = '0;
        e_stb  = '0;
        for (int i = 0; i < NCH; i++) begin
            hit = ok && (int'(cfg_ch) == i);
            if (ms == 2 && en) begin
                if (t - m_t0[i] >= m_div[i]) begin
                    m_t0[i] = t;
                    if (m_q[i] != 0) begin
                        m_div[i] = m_q[i];
                        m_q[i] = 0;
                    end
                end
            end else if (m_q[i] != 0) begin
                m_div[i] = m_q[i];
                m_q[i] = 0;
            end
            if (hit) begin
`ifdef ADC_CLK_DIV_GEN_PHASE_EN
                m_ph[i] = int'(cfg_phase);
`endif
                if (runwr) m_q[i] = dv;
                else m_div[i] = dv;
            end
            if (ms == 1 && en) begin
                ph = (m_ph[i] >= m_div[i]) ? m_div[i] - 1 : m_ph[i];
                m_t0[i] = (ph == 0) ? t : t - (m_div[i] - ph);
            end
            if (en && ms != 0) begin
                e_oclk[i] = ((t - m_t0[i]) < (m_div[i] / 2));
                e_stb[i]  = (t == m_t0[i]);
            end
        end
        if (!en) begin
            ms = 0;
            lk = 0;
            e_lock = 1'b0;
        end else if (ms != 2) begin
            ms = ms + 1;
            lk = 0;
            e_lock = 1'b0;
        end else begin
            if (runwr || bprev) lk = 0;
            else if (lk < LC) lk++;
            e_lock = !runwr && !bprev && (lk == LC);
        end
        e_busy = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (m_q[i] != 0) e_busy = 1'b1;
        end
    endtask

    task automatic cmp_all();
        chk("outclk", 32'(outclk), 32'(e_oclk));
        chk("stb", 32'(stb), 32'(e_stb));
        chk("locked", 32'(locked), 32'(e_lock));
        chk("busy", 32'(busy), 32'(e_busy));
    endtask

    task automatic step();
        @(posedge refclk);
        model_edge();
        @(negedge refclk);
        cmp_all();
    endtask

    task automatic wr(input int ch, input int dv, input int ph);
        cfg_we    = 1'b1;
        cfg_ch    = 3'(ch);
        cfg_div   = 16'(dv);
        cfg_phase = 16'(ph);
        step();
        cfg_we = 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset();
        cfg_we = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_outclk", 32'(outclk), 32'd0);
        chk("rst_stb", 32'(stb), 32'd0);
        chk("rst_locked", 32'(locked), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        mreset();
        @(posedge refclk);
        @(negedge refclk);
        rst_n = 1'b1;
        cmp_all();
    endtask

    initial begin
        int k;
        bit seen;
        int wrate;
        t = 0;
        mreset();
        @(negedge refclk);
        cmp_all();
        rst_n = 1'b1;

        wr(0, 4, 0);
        wr(1, 5, 0);
        wr(2, 0, 0);
        wr(3, 1, 0);
        wr(4, 8, 2);
        wr(6, 3, 0);

        en = 1'b1;
        k = 0;
        seen = 1'b0;
        while (!seen && k < 60) begin
            step();
            k++;
            if (locked === 1'b1) seen = 1'b1;
        end
        chk("lock_lat", 32'(k), 32'd18);

        run(5);
        wr(0, 6, 0);
        run(45);
        en = 1'b0;
        step();
        en = 1'b1;
        run(30);

        wrate = 80;
        for (int n = 0; n < 3000; n++) begin
            if (n % 200 == 0) wrate = ($urandom_range(0, 1) != 0) ? 6 : 80;
            en        = ($urandom_range(0, 99) != 0);
            cfg_we    = ($urandom_range(0, wrate - 1) == 0);
            cfg_ch    = 3'($urandom_range(0, 7));
            cfg_div   = 16'($urandom_range(0, 12));
            cfg_phase = 16'($urandom_range(0, 12));
            if (n == 1500) do_reset();
            else step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/adc_clk_div_gen.md
# adc_clk_div_gen

Parametrised multi-channel clock generator for the ADC capture path. It derives `NUM_CH` programmable divided clocks and matching one-cycle strobes from a single fast fabric clock. Its sibling, the fixed-ratio PLL wrapper, supplies that fast clock. The block adds runtime-programmable divide ratio and phase per channel, glitch-free ratio changes, and a `locked` indication. It sits between the PLL output and the ADC interface and sampling logic.

## Interface
- `NUM_CH`, default 5: number of output channels (1–16).
- `CNT_W`, default 16: width of divide and phase fields.
- `LOCK_CYCLES`, default 16: refclk cycles of stable running before `locked` asserts.

Ports:
- `refclk`  in  1  single clock for all logic; the fast PLL output.
- `rst_n`  in  1  asynchronous, active-low reset.
- `en`  in  1  run enable; low forces idle.
- `cfg_we`  in  1  configuration write strobe, one cycle.
- `cfg_ch`  in  $clog2(NUM_CH)  channel addressed by the write.
- `cfg_div`  in  CNT_W  period in refclk cycles.
- `cfg_phase`  in  CNT_W  phase delay in refclk cycles (see Configuration).
- `outclk`  out  NUM_CH  divided clocks, registered.
- `stb`  out  NUM_CH  one-cycle pulse coincident with each `outclk` rising edge.
- `locked`  out  1  all channels aligned and stable.
- `busy`  out  1  at least one channel has a pending shadowed ratio change.

## Operation
- Each channel holds `div`, `phase`, a shadow `div` with a pending flag, and counter `cnt` (0..div-1).
- `cfg_div` values 0 and 1 are stored as 2.
- `phase` values ≥ div are clamped to div-1 at the point of use.
- High time is floor(div/2) and low time is ceil(div/2). `outclk[i]` = (cnt < floor(div/2)); `stb[i]` = (cnt == 0).
- States:
  - IDLE: counters 0, outputs low, `locked` 0. `en`=1 moves to ALIGN.
  - ALIGN: one cycle. Every `cnt` is preloaded with (phase==0 ? 0 : div-phase). Moves to RUN.
  - RUN: counters increment and wrap at div-1. The lock counter counts up to LOCK_CYCLES, then `locked`=1.
  - `en`=0 in any state moves to IDLE on the next edge.
- Writes in IDLE or ALIGN update `div` and `phase` immediately.
- Writes in RUN:
  - `div` goes to the shadow register and sets the pending flag. It is applied at that channel's next wrap (cnt == div-1 → cnt = 0 with the new div), so there is no runt pulse.
  - `phase` is stored but takes effect only at the next ALIGN.
  - Any RUN write clears `locked` and restarts the lock counter. It does not realign channels.
- Lock counter holds at 0 while `busy`=1.
- A write to the same channel while its shadow is pending overwrites the shadow.
- `cfg_ch` ≥ NUM_CH: the write is ignored.

## Timing
- All outputs are registered. Reset values: `outclk`=0, `stb`=0, `locked`=0, `busy`=0, all `div`=2, all `phase`=0, state IDLE.
- `rst_n` low clears everything asynchronously, mid-run included. Release is synchronous to the next `refclk` edge.
- `en` sampled high at edge E0 gives ALIGN after E0. After E1, phase-0 channels show `outclk`=1 and `stb`=1.
- `locked` rises LOCK_CYCLES edges after the first RUN edge when no write is pending.
- `en` sampled low: all outputs 0 after that same edge.
- `cfg_we` coincident with a channel wrap in RUN: the new div is applied at the following wrap, not the current one.
- `cfg_we` coincident with `en` falling: the write is accepted as an IDLE write.
- `busy` rises the edge after the shadowed write. It falls the edge the last pending shadow is applied.

## Configuration
- `ADC_CLK_DIV_GEN_PHASE_EN` defined:
  - Per-channel `phase` registers exist.
  - ALIGN preloads counters as above.
- Macro undefined:
  - `cfg_phase` is ignored and no phase storage is built.
  - ALIGN preloads every counter with 0, so all channel rising edges coincide.

## Test plan
- NUM_CH=5, ch0 div=4, `en`=1: `outclk[0]` repeats 1,1,0,0. `stb[0]` pulses every 4 cycles. `locked`=1 at RUN+16.
- ch1 div=5: high for 2 cycles, low for 3. ch2 cfg_div=0 and ch3 cfg_div=1: both behave as div=2.
- Macro defined, ch0 div=8 phase=0, ch1 div=8 phase=2: ch1 rises exactly 2 cycles after ch0. With the macro undefined, both rise together.
- In RUN, write ch0 div 4→6 mid-period: the current 4-cycle period completes, the next is 6 cycles, and no pulse is shorter than 2 cycles. `busy` is high until the swap. `locked` drops, then re-asserts 16 cycles after `busy` clears.
- `en` dropped mid-high of ch0: all `outclk`/`stb` are 0 after the next edge. Re-raising `en` realigns all channels.
- `rst_n` pulsed low mid-run: outputs 0 asynchronously. Configuration returns to div=2 and phase=0.
